// File: rtl/mds_issue_arbiter.sv
// rtl/mds_issue_arbiter.sv - round-robin issue arbiter sharing one mul/div/shift unit
//
// Two requesters share a single fwrisc_mul_div_shift unit. One operation is in
// flight at a time. Its result is returned on the rsp_* channel, tagged with
// the id of the requester that issued it.
//
// Optional build macro: MDS_CONST_TIME_EN. When it is defined, every response,
// including a NOP, appears exactly MAX_LAT+1 cycles after the ISSUE cycle.
// err_overrun flags a unit that took longer than that.
//
// Ports:
//   clk, rst                         clock (rising edge), async active-low reset
//   reqN_valid/ready/a/b/op          requester N operation handshake (N = 0, 1)
//   rsp_valid/ready/data/id          response handshake, result and requester id
//   err_overrun                      sticky unit-too-slow flag (constant-time build only)
//   mds_in_valid/mds_a/mds_b/mds_op  one-cycle issue strobe and operands to the unit
//   mds_out/mds_out_valid            unit result and its one-cycle strobe
module mds_issue_arbiter #(
  parameter int MAX_LAT = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_id,
  output logic        err_overrun,
  output logic        mds_in_valid,
  output logic [31:0] mds_a,
  output logic [31:0] mds_b,
  output logic [3:0]  mds_op,
  input  logic [31:0] mds_out,
  input  logic        mds_out_valid
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, BUSY = 2'd2, RESP = 2'd3} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             grant1, take, sel_nop;
  logic [31:0]      sel_a, sel_b;
  logic [3:0]       sel_op;

  if (MAX_LAT >= (1 << CNT_W)) begin : g_cfg_check
    $error("mds_issue_arbiter: MAX_LAT must be below 2**CNT_W");
  end

  // Grant: a lone valid wins. On a tie the requester that did not win last time wins.
  always_comb begin
    grant1     = req1_valid && (!req0_valid || !last_grant);
    take       = (state == IDLE) && (req0_valid || req1_valid);
    sel_a      = grant1 ? req1_a  : req0_a;
    sel_b      = grant1 ? req1_b  : req0_b;
    sel_op     = grant1 ? req1_op : req0_op;
    sel_nop    = (sel_op >= 4'd9);
    req0_ready = (state == IDLE) && req0_valid && !grant1;
    req1_ready = (state == IDLE) && grant1;
  end

  assign cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;
  assign rsp_valid = (state == RESP);

`ifdef MDS_CONST_TIME_EN
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MAX_LAT);

  // have_q: the result, or the implicit NOP zero, is already in rsp_data and
  // is held there until the fixed latency expires.
  logic have_q, err_q, at_lat, overrun_now;

  assign at_lat       = (cnt >= LAT_CNT);
  assign overrun_now  = (state == BUSY) && at_lat && !have_q && !mds_out_valid;
  assign err_overrun  = err_q || overrun_now;
  // A NOP walks through ISSUE so that its timing matches a real op, but it never strobes the unit.
  assign mds_in_valid = (state == ISSUE) && (mds_op < 4'd9);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      have_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (take)
        have_q <= sel_nop;
      else if (state == BUSY && mds_out_valid)
        have_q <= 1'b1;
      if (overrun_now)
        err_q <= 1'b1;
    end
  end
`else
  assign err_overrun  = 1'b0;
  assign mds_in_valid = (state == ISSUE);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (take) begin
`ifdef MDS_CONST_TIME_EN
          state_nxt = ISSUE;
`else
          state_nxt = sel_nop ? RESP : ISSUE;
`endif
        end
      end
      ISSUE: state_nxt = BUSY;
      BUSY: begin
`ifdef MDS_CONST_TIME_EN
        if (at_lat && (have_q || mds_out_valid))
          state_nxt = RESP;
`else
        if (mds_out_valid)
          state_nxt = RESP;
`endif
      end
      RESP: begin
        if (rsp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // The counter is zero during the ISSUE cycle and counts the cycles elapsed since then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
      mds_a      <= '0;
      mds_b      <= '0;
      mds_op     <= '0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      cnt        <= '0;
    end else begin
      if (take) begin
        mds_a      <= sel_a;
        mds_b      <= sel_b;
        mds_op     <= sel_op;
        rsp_id     <= grant1;
        last_grant <= grant1;
        cnt        <= '0;
        if (sel_nop)
          rsp_data <= '0;
      end
      if (state == ISSUE || state == BUSY)
        cnt <= cnt_inc;
`ifdef MDS_CONST_TIME_EN
      if (state == BUSY && mds_out_valid && !have_q)
        rsp_data <= mds_out;
`else
      if (state == BUSY && mds_out_valid)
        rsp_data <= mds_out;
`endif
    end
  end

endmodule

// File: tb/tb_mds_issue_arbiter.sv
// tb/tb_mds_issue_arbiter.sv - scoreboard bench for mds_issue_arbiter
module tb_mds_issue_arbiter;
`ifdef MDS_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic        clk, rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, err_overrun;
  logic [31:0] rsp_data;
  logic        mds_in_valid, mds_out_valid;
  logic [31:0] mds_a, mds_b, mds_out;
  logic [3:0]  mds_op;

  int total, bad, cyc;
  int unit_lat, unit_cnt;
  logic [31:0] unit_res;

  typedef struct { logic [31:0] data; logic id; } exp_t;
  exp_t exp_q[$];

  mds_issue_arbiter #(.MAX_LAT(40), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .err_overrun(err_overrun),
    .mds_in_valid(mds_in_valid), .mds_a(mds_a), .mds_b(mds_b), .mds_op(mds_op),
    .mds_out(mds_out), .mds_out_valid(mds_out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input bit id, output bit got);
    got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
    end
  endtask

  // Unit stand-in: a result appears unit_lat cycles after the issue strobe.
  initial begin
    mds_out = '0;
    mds_out_valid = 1'b0;
    unit_cnt = 0;
    unit_res = '0;
    forever begin
      @(negedge clk);
      mds_out_valid = 1'b0;
      if (unit_cnt > 0) begin
        unit_cnt--;
        if (unit_cnt == 0) begin
          mds_out_valid = 1'b1;
          mds_out = unit_res;
        end
      end
      if (mds_in_valid === 1'b1) begin
        case (mds_op)
          4'd0:    unit_res = mds_a << mds_b[4:0];
          4'd3:    unit_res = mds_a * mds_b;
          4'd7:    unit_res = mds_a / mds_b;
          4'd8:    unit_res = mds_a % mds_b;
          default: unit_res = 32'hdead_beef;
        endcase
        unit_cnt = unit_lat;
      end
    end
  end

  // Monitor: compare each accepted response against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (req0_ready === 1'b1 || req1_ready === 1'b1)
        check1("single_grant", req0_ready & req1_ready, 1'b0);
      if (rst === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got data %0d id %b expected no response", rsp_data, rsp_id);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check1("rsp_id", rsp_id, e.id);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string nm);
    check1({nm, "_rsp_valid"}, rsp_valid, 1'b0);
    check({nm, "_rsp_data"}, rsp_data, 32'd0);
    check1({nm, "_rsp_id"}, rsp_id, 1'b0);
    check1({nm, "_mds_in_valid"}, mds_in_valid, 1'b0);
    check({nm, "_mds_a"}, mds_a, 32'd0);
    check({nm, "_mds_b"}, mds_b, 32'd0);
    check({nm, "_mds_op"}, 32'(mds_op), 32'd0);
    check1({nm, "_err_overrun"}, err_overrun, 1'b0);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b1;
    step();
  endtask

  task automatic run_op(input string nm, input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input int lat, input logic [31:0] exp, input int off,
                        input bit exp_issue);
    bit got;
    int t;
    exp_t e;
    unit_lat = lat;
    if (id) begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end
    wait_grant(id, got);
    check1({nm, "_grant"}, got, 1'b1);
    t = cyc;
    e.data = exp;
    e.id = id;
    exp_q.push_back(e);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check1({nm, "_issue_strobe"}, mds_in_valid, exp_issue);
    if (exp_issue) begin
      check({nm, "_mds_a"}, mds_a, a);
      check({nm, "_mds_b"}, mds_b, b);
      check({nm, "_mds_op"}, 32'(mds_op), 32'(op));
    end
    got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check1({nm, "_rsp_seen"}, got, 1'b1);
    check({nm, "_rsp_cycle"}, cyc - t, off);
    step();
  endtask

  initial begin
    bit   got;
    int   grants, t;
    exp_t e;
    total = 0;
    bad = 0;
    unit_lat = 0;
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;

    reset_dut();
    run_op("mul", 1'b0, 32'd7, 32'd6, 4'd3, 3, 32'd42, CT ? 42 : 5, 1'b1);

    // Both requesters valid continuously: grants start at 0 after reset and then alternate.
    reset_dut();
    unit_lat = 2;
    req0_a = 32'd100; req0_b = 32'd7; req0_op = 4'd7;
    req1_a = 32'd100; req1_b = 32'd7; req1_op = 4'd8;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    grants = 0;
    for (int n = 0; n < 400 && grants < 4; n++) begin
      #1;
      if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
        check("alt_one_in_flight", exp_q.size(), 32'd0);
        check1("alt_order", req1_ready, (grants % 2) == 1);
        e.id = ((grants % 2) == 1);
        e.data = e.id ? 32'd2 : 32'd14;
        exp_q.push_back(e);
        grants++;
      end
      @(posedge clk);
    end
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("alt_grants", grants, 32'd4);
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) step();
    check("alt_drain", exp_q.size(), 32'd0);
    step();

    run_op("nop", 1'b1, 32'd0, 32'd0, 4'b1010, 0, 32'd0, CT ? 42 : 1, 1'b0);

    // Consumer stalls for 10 cycles: the response must hold and nobody may be granted.
    rsp_ready = 1'b0;
    unit_lat = 2;
    req0_a = 32'd3; req0_b = 32'd4; req0_op = 4'd0; req0_valid = 1'b1;
    req1_a = 32'd0; req1_b = 32'd0; req1_op = 4'hf; req1_valid = 1'b1;
    wait_grant(1'b0, got);
    check1("hold_grant", got, 1'b1);
    e.data = 32'd48; e.id = 1'b0;
    exp_q.push_back(e);
    step();
    req0_valid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check1("hold_rsp_seen", got, 1'b1);
    for (int k = 0; k < 10; k++) begin
      check1("hold_valid", rsp_valid, 1'b1);
      check("hold_data", rsp_data, 32'd48);
      check1("hold_id", rsp_id, 1'b0);
      check1("hold_req0_ready", req0_ready, 1'b0);
      check1("hold_req1_ready", req1_ready, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check1("hold_idle_grant", req1_ready, 1'b1);
    e.data = 32'd0; e.id = 1'b1;
    exp_q.push_back(e);
    step();
    req1_valid = 1'b0;
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) step();
    check("hold_drain", exp_q.size(), 32'd0);
    step();

`ifdef MDS_CONST_TIME_EN
    run_op("ct_sll", 1'b0, 32'd1, 32'd5, 4'd0, 1, 32'd32, 42, 1'b1);
    run_op("ct_div", 1'b1, 32'd100, 32'd7, 4'd7, 34, 32'd14, 42, 1'b1);
    // A unit stalled for 45 cycles overruns MAX_LAT; the response follows the late result.
    unit_lat = 45;
    req0_a = 32'd2; req0_b = 32'd3; req0_op = 4'd3; req0_valid = 1'b1;
    wait_grant(1'b0, got);
    check1("ovr_grant", got, 1'b1);
    t = cyc;
    e.data = 32'd6; e.id = 1'b0;
    exp_q.push_back(e);
    step();
    req0_valid = 1'b0;
    for (int n = 0; n < 100 && cyc < t + 40; n++) step();
    check1("ovr_err_before", err_overrun, 1'b0);
    step();
    check1("ovr_err_at_lat", err_overrun, 1'b1);
    got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check1("ovr_rsp_seen", got, 1'b1);
    check("ovr_rsp_cycle", cyc - t, 32'd47);
    step();
    check1("ovr_err_sticky", err_overrun, 1'b1);
`endif

    // Reset while BUSY: the op is abandoned and its late result is ignored.
    rsp_ready = 1'b1;
    unit_lat = 20;
    req0_a = 32'd5; req0_b = 32'd5; req0_op = 4'd3; req0_valid = 1'b1;
    wait_grant(1'b0, got);
    check1("rb_grant", got, 1'b1);
    step();
    req0_valid = 1'b0;
    repeat (4) step();
    rst = 1'b0;
    #1;
    check_reset_outputs("rb_async");
    step();
    step();
    rst = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (rsp_valid === 1'b1) got = 1'b1;
    end
    check1("rb_late_ignored", got, 1'b0);
    check("rb_queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mds_issue_arbiter.md
Name: mds_issue_arbiter

Overview:
- Shares one fwrisc_mul_div_shift unit between two requesters (req0, req1) with valid/ready handshakes.
- Arbitrates round-robin, issues exactly one operation at a time, captures the result and returns it tagged with the requester id.
- Under an optional macro, pads every response to a fixed latency so completion timing is independent of op and operands.

Parameters:
- MAX_LAT, 40, cycles from ISSUE to padded response; must cover worst-case unit latency.
- CNT_W, 6, latency counter width; MAX_LAT < 2**CNT_W.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  32  requester 0 operand a
- req0_b  in  32  requester 0 operand b
- req0_op  in  4  requester 0 op (0 SLL, 1 SRL, 2 SRA, 3 MUL, 4 MULH, 5 MULS, 6 MULSH, 7 DIV, 8 REM, >=9 NOP)
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as req0 for requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_data  out  32  result
- rsp_id  out  1  requester that issued the op
- err_overrun  out  1  sticky: unit exceeded MAX_LAT (CONST_TIME_EN only; tied 0 otherwise)
- mds_in_valid  out  1  one-cycle issue strobe to unit
- mds_a, mds_b  out  32  operands to unit
- mds_op  out  4  op to unit
- mds_out  in  32  unit result
- mds_out_valid  in  1  unit result strobe (one cycle)

Behaviour:
- Reset (rst=0, async): state IDLE; rsp_valid=0, rsp_data=0, rsp_id=0, mds_in_valid=0, mds_a/b=0, mds_op=0, err_overrun=0, last_grant=1 (req0 wins first tie), counter=0. Reset mid-operation abandons the op; any later mds_out_valid is ignored in IDLE.
- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - Grant is combinational: only one valid -> that one; both valid -> the one != last_grant.
  - reqX_ready=1 only for the granted requester, only in IDLE.
  - On handshake (cycle T): latch a, b, op and id; update last_grant; -> ISSUE.
  - Op >= 9 (NOP): not issued; -> RESP at T+1 with rsp_data=0.
- ISSUE (T+1): mds_in_valid=1 for exactly this cycle with latched operands; counter cleared to 0; -> BUSY.
- BUSY: counter increments each cycle, saturating at 2**CNT_W-1. On mds_out_valid, capture mds_out into rsp_data; -> RESP next cycle.
  - mds_out_valid coincident with ISSUE is impossible (unit latency >= 1) and is ignored.
- RESP: rsp_valid=1 with rsp_data and rsp_id held stable until rsp_ready. On rsp_valid&rsp_ready -> IDLE; the next grant is possible the following cycle.
- Back-to-back throughput: one op per (unit latency + 3) cycles with rsp_ready held high.
- mds_out_valid outside BUSY is ignored; no error is raised.
- Fairness: with both requesters continuously valid, grants strictly alternate.

Optional Feature:
- Macro: MDS_CONST_TIME_EN.
- Defined:
  - RESP is entered exactly when counter == MAX_LAT, i.e. rsp_valid first rises at ISSUE cycle + MAX_LAT + 1 for every op, including NOP (NOP also passes through ISSUE/BUSY with mds_in_valid=0).
  - Results arriving earlier are held internally.
  - If counter reaches MAX_LAT without a result: err_overrun set (sticky until reset), FSM waits in BUSY for mds_out_valid, then RESP.
- Undefined:
  - Latency follows the unit; NOP takes the short path; err_overrun constant 0.

Test Plan:
- Reset then req0 MUL a=7 b=6, unit returns 42 after 3 cycles, rsp_ready=1 -> req0_ready at T, mds_in_valid at T+1, rsp_valid with rsp_data=42, rsp_id=0 at T+5.
- req0 and req1 both valid continuously with DIV 100/7 and REM 100/7 -> grants alternate 0,1,0,1; responses 14 (id 0) and 2 (id 1); never two grants in flight.
- req1 op=4'b1010 (NOP), without macro -> no mds_in_valid; rsp_valid at T+1, rsp_data=0, rsp_id=1.
- rsp_ready held 0 for 10 cycles in RESP -> rsp_data/rsp_id stable; req0_ready and req1_ready stay 0; release gives completion and IDLE next cycle.
- MDS_CONST_TIME_EN, MAX_LAT=40: SLL returning after 1 cycle and DIV after 34 cycles -> both rsp_valid at ISSUE+41. Unit stalled 45 cycles -> err_overrun=1 at ISSUE+40; response at result arrival +1.
- Assert rst low while in BUSY, drop mds_out_valid during reset, release -> all outputs at reset values; late mds_out_valid produces no response.
